// File: rtl/tl_cpl_tracker.sv
// Tracks outstanding non-posted tags and retires them on completion or flush; free/done/unexp/rec_err are registered, 1 cycle after acceptance.
// Completions take full rate in IDLE; cpl_ready_o drops for the DEPTH-cycle flush scan.
module tl_cpl_tracker #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 256,
  parameter int BC_W  = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rec_valid_i,
  input  logic [TAG_W-1:0] rec_tag_i,
  input  logic [BC_W-1:0]  rec_bytes_i,
  input  logic             cpl_valid_i,
  output logic             cpl_ready_o,
  input  logic [TAG_W-1:0] cpl_tag_i,
  input  logic [2:0]       cpl_status_i,
  input  logic [BC_W-1:0]  cpl_bytes_i,
  input  logic             flush_i,
  output logic             free_valid_o,
  output logic [TAG_W-1:0] free_tag_o,
  output logic             done_valid_o,
  output logic [TAG_W-1:0] done_tag_o,
  output logic             done_err_o,
  output logic             unexp_cpl_o,
  output logic             rec_err_o,
  output logic [TAG_W:0]   outstanding_o
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             rdy_q;
  logic             scan_act;
  logic [TAG_W-1:0] scan_q;
  logic             scan_last;
  logic [DEPTH-1:0] vld_q;
  logic [BC_W-1:0]  rem_q [DEPTH];

  logic             cpl_acc, cpl_hit, cpl_sc, cpl_part, cpl_ret, cpl_err;
  logic [BC_W-1:0]  cpl_rem;
  logic             scan_ret, ret, ret_err, rec_busy, rec_new;
  logic [TAG_W-1:0] ret_tag;

  assign scan_last = (scan_q == TAG_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_i)   state_d = FLUSH;
      FLUSH:   if (scan_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rdy_q holds ready low until the first edge after reset release
  always_comb begin
    cpl_ready_o = (state_q == IDLE) && rdy_q;
    scan_act    = (state_q == FLUSH);
  end

  always_comb begin
    cpl_acc  = cpl_valid_i && cpl_ready_o;
    cpl_rem  = rem_q[cpl_tag_i];
    cpl_sc   = (cpl_status_i == 3'b000);
    cpl_hit  = cpl_acc && vld_q[cpl_tag_i];
    cpl_part = cpl_hit && cpl_sc && (cpl_bytes_i < cpl_rem);
    cpl_ret  = cpl_hit && !cpl_part;
    cpl_err  = !cpl_sc || (cpl_bytes_i > cpl_rem);
    scan_ret = scan_act && vld_q[scan_q];
    ret      = cpl_ret || scan_ret;
    ret_tag  = scan_act ? scan_q : cpl_tag_i;
    ret_err  = scan_act ? 1'b1 : cpl_err;
    // A same-cycle retire of the recorded tag lets the record count as new
    rec_busy = vld_q[rec_tag_i] && !(ret && (ret_tag == rec_tag_i));
    rec_new  = rec_valid_i && !rec_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      scan_q <= '0;
    end else begin
      rdy_q  <= 1'b1;
      scan_q <= scan_act ? scan_q + 1'b1 : '0;
    end
  end

  // Record is written last so it overrides a same-cycle completion update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) rem_q[i] <= '0;
    end else begin
      if (ret)      vld_q[ret_tag] <= 1'b0;
      if (cpl_part) rem_q[cpl_tag_i] <= cpl_rem - cpl_bytes_i;
      if (rec_valid_i) begin
        vld_q[rec_tag_i] <= 1'b1;
        rem_q[rec_tag_i] <= rec_bytes_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_valid_o  <= 1'b0;
      free_tag_o    <= '0;
      done_valid_o  <= 1'b0;
      done_tag_o    <= '0;
      done_err_o    <= 1'b0;
      unexp_cpl_o   <= 1'b0;
      rec_err_o     <= 1'b0;
      outstanding_o <= '0;
    end else begin
      free_valid_o  <= ret;
      free_tag_o    <= ret_tag;
      done_valid_o  <= ret;
      done_tag_o    <= ret_tag;
      done_err_o    <= ret && ret_err;
      unexp_cpl_o   <= cpl_acc && !vld_q[cpl_tag_i];
      rec_err_o     <= rec_valid_i && rec_busy;
      outstanding_o <= outstanding_o + (TAG_W+1)'(rec_new) - (TAG_W+1)'(ret);
    end
  end

endmodule

// File: doc/tl_cpl_tracker.md
TL_CPL_TRACKER -- requirements
Module: tl_cpl_tracker

Interface
REQ-001 Parameter TAG_W, default 8, tag width.
REQ-002 Parameter DEPTH, default 256, number of trackable tags (2**TAG_W).
REQ-003 Parameter BC_W, default 13, byte-count width (max 4096 bytes per request).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rec_valid_i  in  1  record new outstanding non-posted request (pulse, same cycle tag is granted).
REQ-007 rec_tag_i  in  TAG_W  tag of recorded request.
REQ-008 rec_bytes_i  in  BC_W  requested byte total, 1..4096.
REQ-009 cpl_valid_i  in  1  completion header valid.
REQ-010 cpl_ready_o  out  1  completion header accepted when valid && ready.
REQ-011 cpl_tag_i  in  TAG_W  completion tag.
REQ-012 cpl_status_i  in  3  completion status (000 = SC).
REQ-013 cpl_bytes_i  in  BC_W  payload bytes carried by this completion (0 for non-SC).
REQ-014 flush_i  in  1  pulse: retire every outstanding tag.
REQ-015 free_valid_o / free_tag_o  out  1 / TAG_W  tag release to tag allocator.
REQ-016 done_valid_o / done_tag_o / done_err_o  out  1 / TAG_W / 1  request retirement report; err = non-SC, overflow, or flushed.
REQ-017 unexp_cpl_o  out  1  pulse: completion for non-outstanding tag.
REQ-018 rec_err_o  out  1  pulse: rec_valid_i on already-outstanding tag.
REQ-019 outstanding_o  out  TAG_W+1  count of outstanding tags.

Function
REQ-020 Per tag SHALL hold valid bit and BC_W-bit remaining count; rec sets valid=1, remaining=rec_bytes_i.
REQ-021 rec on valid tag SHALL overwrite remaining, pulse rec_err_o next cycle, not change outstanding_o.
REQ-022 FSM states IDLE, FLUSH; IDLE->FLUSH on flush_i; FLUSH->IDLE after index DEPTH-1 processed.
REQ-023 cpl_ready_o SHALL be 1 in IDLE, 0 in FLUSH and during reset.
REQ-024 Accepted completion, tag valid, status SC, cpl_bytes_i < remaining: remaining -= cpl_bytes_i, no outputs.
REQ-025 Accepted completion, tag valid, status SC, cpl_bytes_i == remaining: clear valid, free+done with err=0.
REQ-026 Accepted completion, tag valid, cpl_bytes_i > remaining or status non-SC: clear valid, free+done with err=1.
REQ-027 Accepted completion, tag invalid: pulse unexp_cpl_o, state unchanged, no free/done.
REQ-028 All outputs except cpl_ready_o SHALL be registered; latency acceptance->free/done/unexp = 1 cycle, single-cycle pulses.
REQ-029 Back-to-back completions same tag SHALL see previous cycle's update (no stale read); full throughput 1/cycle.
REQ-030 rec and completion same cycle same tag: completion evaluated against pre-rec state, then rec applies (rec wins).
REQ-031 FLUSH scans index 0..DEPTH-1, one per cycle; valid entry -> clear, free+done err=1; invalid -> no output.
REQ-032 rec_valid_i during FLUSH SHALL be recorded normally; a tag recorded at an index already scanned stays outstanding.
REQ-033 flush_i while in FLUSH SHALL be ignored.
REQ-034 outstanding_o +1 per new rec, -1 per retire; simultaneous rec and retire of different tags -> net 0.

Reset
REQ-035 rst_n low: all valid bits 0, remaining 0, FSM IDLE, scan index 0, all pulse outputs 0, outstanding_o 0, cpl_ready_o 0.
REQ-036 Reset mid-FLUSH or mid-transfer SHALL abandon all state with no free/done emitted.
REQ-037 cpl_ready_o SHALL go 1 on first clock edge after rst_n deasserts.

Verification
REQ-038 rec tag 5 bytes 256; cpl tag 5 SC 128, then 128 -> first no output, second free_tag_o=5, done_err_o=0, outstanding 1->0.
REQ-039 cpl tag 9 with no rec -> unexp_cpl_o=1 one cycle, outstanding_o unchanged, no free.
REQ-040 rec tag 3 bytes 64; cpl tag 3 status 001 -> free_tag_o=3, done_err_o=1; rec tag 3 bytes 32; cpl 64 -> free 3, done_err_o=1 (overflow).
REQ-041 rec tags 0,7,255; flush_i -> cpl_ready_o=0 for 256 cycles, free 0,7,255 in order with err=1, outstanding_o=0.
REQ-042 rec tag 2 bytes 12; cpls tag 2 of 4 bytes on 3 consecutive cycles -> single free_tag_o=2 after third, done_err_o=0.
REQ-043 Assert rst_n low during FLUSH with 2 outstanding -> no free pulses, outstanding_o=0, cpl_ready_o=1 after release.
